// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controllers: phase encoding and
// width helpers used to size road indices and timers.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_AMBER  = 2'd1,
        PH_ALLRED = 2'd2,
        PH_FLASH  = 2'd3
    } phase_e;

    // Road index width; a two-road junction still needs one bit.
    function automatic int road_w(input int num_roads);
        return (num_roads > 2) ? $clog2(num_roads) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_road_picker.sv
// Round-robin selector: first requesting road after cur_road, scanning
// upward with wrap-around. The current road itself is never a candidate.
module rr_road_picker
    import traffic_pkg::*;
#(
    parameter int  NUM_ROADS = 4,
    localparam int ROAD_W    = road_w(NUM_ROADS)
) (
    input  logic [NUM_ROADS-1:0] req,
    input  logic [ROAD_W-1:0]    cur_road,
    output logic [ROAD_W-1:0]    nxt_road,
    output logic                 found
);

    localparam logic [ROAD_W:0] ROADS = (ROAD_W+1)'(NUM_ROADS);

    logic [NUM_ROADS-1:1] hit;
    logic [ROAD_W-1:0]    cand [1:NUM_ROADS-1];

    // cand[gi] is the road gi positions after cur_road, modulo NUM_ROADS.
    for (genvar gi = 1; gi < NUM_ROADS; gi++) begin : g_cand
        logic [ROAD_W:0] sum;
        assign sum      = {1'b0, cur_road} + (ROAD_W+1)'(gi);
        assign cand[gi] = (sum >= ROADS) ? ROAD_W'(sum - ROADS) : sum[ROAD_W-1:0];
        assign hit[gi]  = req[cand[gi]];
    end

    // Scan from the far end so the nearest requester wins.
    always_comb begin
        nxt_road = cur_road;
        for (int k = NUM_ROADS - 1; k >= 1; k--) begin
            if (hit[k]) begin
                nxt_road = cand[k];
            end
        end
    end

    assign found = |hit;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-road intersection controller: one green at a time, round-robin service,
// internally timed amber/all-red clearance and a maintenance flash mode.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int  NUM_ROADS         = 4,
    parameter int  MIN_GREEN_CYCLES  = 8,
    parameter int  MAX_GREEN_CYCLES  = 32,
    parameter int  AMBER_CYCLES      = 4,
    parameter int  ALLRED_CYCLES     = 2,
    parameter int  FLASH_HALF_CYCLES = 5,
    localparam int ROAD_W            = road_w(NUM_ROADS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_ROADS-1:0] req,
    input  logic                 flash,
    output logic [NUM_ROADS-1:0] red,
    output logic [NUM_ROADS-1:0] amber,
    output logic [NUM_ROADS-1:0] green,
    output logic [ROAD_W-1:0]    cur_road,
    output logic [1:0]           phase
);

    localparam int MAX_DUR = max_int(max_int(MAX_GREEN_CYCLES, AMBER_CYCLES),
                                     max_int(ALLRED_CYCLES, FLASH_HALF_CYCLES));
    localparam int CNT_W   = $clog2(MAX_DUR) + 1;

    localparam logic [CNT_W-1:0] GREEN_MIN_END = CNT_W'(MIN_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_MAX_END = CNT_W'(MAX_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] AMBER_END     = CNT_W'(AMBER_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALLRED_END    = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_END     = CNT_W'(FLASH_HALF_CYCLES - 1);

    phase_e            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ROAD_W-1:0] cur_road_reg, cur_road_next;
    logic [ROAD_W-1:0] nxt_road_reg, nxt_road_next;
    logic              blink_reg, blink_next;
    logic [ROAD_W-1:0] pick_road;
    logic              other_req;
    logic              green_done;

    rr_road_picker #(
        .NUM_ROADS (NUM_ROADS)
    ) u_picker (
        .req      (req),
        .cur_road (cur_road_reg),
        .nxt_road (pick_road),
        .found    (other_req)
    );

    assign green_done = other_req &&
                        ((cnt_reg >= GREEN_MAX_END) ||
                         (!req[cur_road_reg] && (cnt_reg >= GREEN_MIN_END)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= PH_GREEN;
            cnt_reg      <= '0;
            cur_road_reg <= '0;
            nxt_road_reg <= '0;
            blink_reg    <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cur_road_reg <= cur_road_next;
            nxt_road_reg <= nxt_road_next;
            blink_reg    <= blink_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg + 1'b1;
        cur_road_next = cur_road_reg;
        nxt_road_next = nxt_road_reg;
        blink_next    = blink_reg;

        // Flash pre-empts every timer; the counter doubles as the blink timer.
        if (flash) begin
            state_next = PH_FLASH;
            if (state_reg != PH_FLASH) begin
                cnt_next   = '0;
                blink_next = 1'b1;
            end else if (cnt_reg == FLASH_END) begin
                cnt_next   = '0;
                blink_next = !blink_reg;
            end
        end else begin
            case (state_reg)
                PH_GREEN: begin
                    if (cnt_reg >= GREEN_MAX_END) begin
                        cnt_next = cnt_reg;
                    end
                    if (green_done) begin
                        state_next    = PH_AMBER;
                        cnt_next      = '0;
                        nxt_road_next = pick_road;
                    end
                end
                PH_AMBER: begin
                    if (cnt_reg == AMBER_END) begin
                        state_next = PH_ALLRED;
                        cnt_next   = '0;
                    end
                end
                PH_ALLRED: begin
                    if (cnt_reg == ALLRED_END) begin
                        state_next    = PH_GREEN;
                        cnt_next      = '0;
                        cur_road_next = nxt_road_reg;
                    end
                end
                default: begin
                    // Leaving flash: clear, then restart service from road 0.
                    state_next    = PH_ALLRED;
                    cnt_next      = '0;
                    nxt_road_next = '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_ROADS; gi++) begin : g_lamp
        logic owner;
        assign owner     = (cur_road_reg == ROAD_W'(gi));
        assign green[gi] = (state_reg == PH_GREEN) && owner;
        assign amber[gi] = ((state_reg == PH_AMBER) && owner) ||
                           ((state_reg == PH_FLASH) && blink_reg);
        assign red[gi]   = (state_reg == PH_ALLRED) ||
                           (((state_reg == PH_GREEN) || (state_reg == PH_AMBER)) && !owner);
    end

    assign cur_road = cur_road_reg;
    assign phase    = state_reg;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed and randomized stimulus for traffic_phase_ctrl, compared each cycle
// against a behavioural model of the phase rules.
module tb_traffic_phase_ctrl;

    localparam int N    = 4;
    localparam int MING = 8;
    localparam int MAXG = 32;
    localparam int AMB  = 4;
    localparam int ALR  = 2;
    localparam int FH   = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flash = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] red, amber, green;
    logic [1:0]   cur_road;
    logic [1:0]   phase;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: phase number, cycles spent in the phase so far, owner road,
    // latched target road, flash lamp level.
    int m_phase, m_time, m_cur, m_tgt;
    bit m_lit;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .NUM_ROADS         (N),
        .MIN_GREEN_CYCLES  (MING),
        .MAX_GREEN_CYCLES  (MAXG),
        .AMBER_CYCLES      (AMB),
        .ALLRED_CYCLES     (ALR),
        .FLASH_HALF_CYCLES (FH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .flash    (flash),
        .red      (red),
        .amber    (amber),
        .green    (green),
        .cur_road (cur_road),
        .phase    (phase)
    );

    task automatic model_edge(input bit r, input logic [N-1:0] rq, input bit fl);
        bit others;
        if (r) begin
            m_phase = 0; m_time = 0; m_cur = 0; m_tgt = 0; m_lit = 1'b1;
        end else if (fl) begin
            if (m_phase != 3) begin
                m_phase = 3; m_time = 0; m_lit = 1'b1;
            end else begin
                m_time++;
                if (m_time % FH == 0) m_lit = !m_lit;
            end
        end else begin
            case (m_phase)
                0: begin
                    others = 1'b0;
                    for (int i = 0; i < N; i++) if (i != m_cur && rq[i]) others = 1'b1;
                    if (others && (m_time >= MAXG - 1 || (!rq[m_cur] && m_time >= MING - 1))) begin
                        for (int k = N - 1; k >= 1; k--) if (rq[(m_cur + k) % N]) m_tgt = (m_cur + k) % N;
                        m_phase = 1; m_time = 0;
                    end else begin
                        m_time++;
                    end
                end
                1: if (m_time == AMB - 1) begin m_phase = 2; m_time = 0; end else m_time++;
                2: if (m_time == ALR - 1) begin m_phase = 0; m_time = 0; m_cur = m_tgt; end else m_time++;
                default: begin m_phase = 2; m_time = 0; m_tgt = 0; end
            endcase
        end
    endtask

    function automatic logic [15:0] expected();
        logic [N-1:0] er, ea, eg;
        er = '0; ea = '0; eg = '0;
        for (int i = 0; i < N; i++) begin
            case (m_phase)
                0: begin eg[i] = (i == m_cur); er[i] = (i != m_cur); end
                1: begin ea[i] = (i == m_cur); er[i] = (i != m_cur); end
                2: er[i] = 1'b1;
                default: ea[i] = m_lit;
            endcase
        end
        return {2'(m_phase), 2'(m_cur), er, ea, eg};
    endfunction

    function automatic bit lamps_sane();
        bit ok = $onehot0(green);
        if (phase == 2'd3 && amber == '0) begin
            ok = ok && (red == '0) && (green == '0);
        end else begin
            for (int i = 0; i < N; i++)
                if (int'(red[i]) + int'(amber[i]) + int'(green[i]) != 1) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic cycle(input bit r, input logic [N-1:0] rq, input bit fl);
        logic [15:0] obs, exp_v;
        @(negedge clk);
        rst = r; req = rq; flash = fl;
        @(posedge clk);
        model_edge(r, rq, fl);
        #1;
        vectors++;
        exp_v = expected();
        obs   = {phase, cur_road, red, amber, green};
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL lamps vec=%0d observed=%h expected=%h", vectors, obs, exp_v);
        end
        assert (lamps_sane()) else begin
            miscompares++;
            $error("FAIL lamp_invariant vec=%0d red=%b amber=%b green=%b", vectors, red, amber, green);
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp_v);
        assert (obs == exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        int g, a, ar;
        logic [N-1:0] rq;
        bit fl;

        model_edge(1'b1, '0, 1'b0);

        // Reset then idle: road 0 stays green.
        cycle(1, '0, 0);
        check("reset_green", int'(green), 1);
        check("reset_phase", int'(phase), 0);
        repeat (100) cycle(0, '0, 0);
        check("idle_green", int'(green), 1);
        $display("step reset_idle: phase=%0d green=%b", phase, green);

        // Minimum green, then amber and all-red durations, hand over to road 2.
        g = 0; a = 0; ar = 0;
        cycle(1, '0, 0);
        if (green[0]) g++;
        for (int i = 0; i < 60 && !green[2]; i++) begin
            cycle(0, (i < 2) ? 4'b0000 : 4'b0100, 0);
            if (green[0]) g++;
            if (amber[0]) a++;
            if (phase == 2'd2) ar++;
        end
        check("min_green_len", g, MING);
        check("amber_len", a, AMB);
        check("allred_len", ar, ALR);
        check("handover_road2", int'(cur_road), 2);
        $display("step min_green: green=%0d amber=%0d allred=%0d road=%0d", g, a, ar, cur_road);

        // Busy road 0 yields after the maximum green.
        g = 0;
        cycle(1, 4'b0011, 0);
        if (green[0]) g++;
        for (int i = 0; i < 80 && !green[1]; i++) begin
            cycle(0, 4'b0011, 0);
            if (green[0]) g++;
        end
        check("max_green_len", g, MAXG);
        check("handover_road1", int'(cur_road), 1);
        $display("step max_green: green=%0d road=%0d", g, cur_road);

        // Move to road 3, then check wrap-around selection picks road 0.
        for (int i = 0; i < 40 && !green[3]; i++) cycle(0, 4'b1000, 0);
        check("reach_road3", int'(cur_road), 3);
        for (int i = 0; i < 40 && !(phase == 2'd0 && cur_road != 2'd3); i++) cycle(0, 4'b0011, 0);
        check("wrap_pick", int'(cur_road), 0);
        $display("step wrap: road=%0d", cur_road);

        // Flash during amber, blink pattern, then clearance back to road 0.
        for (int i = 0; i < 60 && phase != 2'd1; i++) cycle(0, 4'b0010, 0);
        check("reach_amber", int'(phase), 1);
        for (int j = 0; j < 25; j++) begin
            cycle(0, 4'b0010, 1);
            check("flash_blink", int'(amber), ((j / FH) % 2 == 0) ? 15 : 0);
        end
        ar = 0;
        for (int i = 0; i < 10 && !green[0]; i++) begin
            cycle(0, '0, 0);
            if (phase == 2'd2) ar++;
        end
        check("flash_clear_len", ar, ALR);
        check("flash_exit_road", int'(cur_road), 0);
        $display("step flash: allred=%0d road=%0d", ar, cur_road);

        // Reset during all-red headed for road 2.
        for (int i = 0; i < 40 && phase != 2'd2; i++) cycle(0, 4'b0100, 0);
        check("reach_allred", int'(phase), 2);
        g = 0;
        cycle(1, 4'b0010, 0);
        check("rst_allred_green", int'(green), 1);
        if (green[0]) g++;
        for (int i = 0; i < 30 && green[0]; i++) begin
            cycle(0, 4'b0010, 0);
            if (green[0]) g++;
        end
        check("rst_cnt_cleared", g, MING);
        $display("step reset_allred: green_len=%0d", g);

        // Randomized traffic with occasional flash and reset.
        rq = '0; fl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) rq = N'($urandom);
            if ($urandom_range(149) == 0) fl = !fl;
            cycle(($urandom_range(999) == 0) ? 1'b1 : 1'b0, rq, fl);
        end
        $display("step random: %0d vectors so far", vectors);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
